usb_writer: RTL

- Full-speed USB packet transmitter; the transmit counterpart of the USB receive path.
- Accepts a PID byte and, optionally, a 64-bit data payload with a 16-bit CRC, and emits a complete packet on the differential pair: SYNC, PID, optional DATA and CRC, then EOP.
- Performs bit stuffing and NRZI encoding, and paces bits from an internal bit-period counter.
- Sits between the device controller and the bus pad drivers.

---
 rtl/usb_tx_pkg.sv | 44 ++++
 rtl/usb_writer_if.sv | 22 ++
 rtl/usb_bit_encoder.sv | 67 ++++++
 rtl/usb_writer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared states, line codes and field sizes for the USB transmitter
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PID,
        DATA,
        CRC,
        EOP_SE0_1,
        EOP_SE0_2,
        EOP_J
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int PID_BITS  = 8;
    localparam int DATA_BITS = 64;
    localparam int CRC_BITS  = 16;

    function automatic int field_bits(tx_state_e s);
        case (s)
            SYNC:    return 8;
            PID:     return PID_BITS;
            DATA:    return DATA_BITS;
            CRC:     return CRC_BITS;
            default: return 1;
        endcase
    endfunction

    function automatic tx_state_e next_field(tx_state_e s, logic has_data);
        case (s)
            SYNC:    return PID;
            PID:     return has_data ? DATA : EOP_SE0_1;
            DATA:    return CRC;
            default: return EOP_SE0_1;
        endcase
    endfunction

endpackage

// File: rtl/usb_writer_if.sv
// rtl/usb_writer_if.sv - packet request and line-side signals of the USB transmitter
interface usb_writer_if;
    logic        start;
    logic        send_data;
    logic [7:0]  PID_data;
    logic [63:0] data;
    logic [15:0] CRC_data;
    logic [1:0]  USBdata;
    logic        tx_en;
    logic        busy;
    logic        EOP_sent;

    modport master (
        output start, send_data, PID_data, data, CRC_data,
        input  USBdata, tx_en, busy, EOP_sent
    );

    modport slave (
        input  start, send_data, PID_data, data, CRC_data,
        output USBdata, tx_en, busy, EOP_sent
    );
endinterface

// File: rtl/usb_bit_encoder.sv
// rtl/usb_bit_encoder.sv - bit stuffing and NRZI line encoding, one decision per bit tick
module usb_bit_encoder
    import usb_tx_pkg::*;
#(
    parameter int STUFF_RUN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_bit,
    input  logic       bit_tick,
    input  logic       se0_req,
    input  logic       pkt_start,
    output logic [1:0] line_state,
    output logic       stuff_now
);

    localparam int OW = $clog2(STUFF_RUN + 1);

    logic [OW-1:0] ones_q, ones_d;
    logic [1:0]    level_q, level_d;
    logic          se0_q, se0_d;
    logic [1:0]    base_level;
    logic [OW-1:0] base_ones;

    // A completed run of ones forces the next period to be a stuffed 0.
    assign stuff_now  = !pkt_start && (ones_q == OW'(STUFF_RUN));
    assign line_state = se0_q ? LINE_SE0 : level_q;

    always_comb begin
        base_level = pkt_start ? LINE_J : level_q;
        base_ones  = pkt_start ? '0 : ones_q;
        level_d    = level_q;
        ones_d     = ones_q;
        se0_d      = se0_q;
        if (bit_tick) begin
            se0_d = 1'b0;
            if (stuff_now) begin
                level_d = ~level_q;
                ones_d  = '0;
            end else if (se0_req) begin
                // Leaving SE0 the bus returns to J, so a following raw 1 yields the EOP J.
                level_d = LINE_J;
                ones_d  = '0;
                se0_d   = 1'b1;
            end else if (raw_bit) begin
                level_d = base_level;
                ones_d  = base_ones + OW'(1);
            end else begin
                level_d = ~base_level;
                ones_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_q  <= '0;
            level_q <= LINE_J;
            se0_q   <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            level_q <= level_d;
            se0_q   <= se0_d;
        end
    end

endmodule

// File: rtl/usb_writer.sv
// rtl/usb_writer.sv - full-speed USB packet transmitter: SYNC, PID, optional DATA+CRC, EOP
module usb_writer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_RUN    = 6
) (
    input  logic         clk,
    input  logic         rst,
    usb_writer_if.slave  bus
);

    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = 7;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]  pid_q, pid_d;
    logic [63:0] data_q, data_d;
    logic [15:0] crc_q, crc_d;
    logic        send_data_q, send_data_d;
    logic        busy_q, busy_d;
    logic        eop_q, eop_d;

    logic        pkt_start;
    logic        bit_tick;
    logic        stuff_now;
    logic        raw_bit;
    logic        se0_req;
    logic [1:0]  line_state;

    assign pkt_start = (state_q == IDLE) && bus.start;
    assign bit_tick  = pkt_start || ((state_q != IDLE) && (bit_cnt_q == CNT_LAST));

    // state_q/idx_q name the bit currently on the line; a stuffed bit leaves them in place.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bit_cnt_d   = bit_cnt_q;
        pid_d       = pid_q;
        data_d      = data_q;
        crc_d       = crc_q;
        send_data_d = send_data_q;
        busy_d      = busy_q;
        eop_d       = 1'b0;

        if (state_q != IDLE) begin
            bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CW'(1);
        end

        if (pkt_start) begin
            pid_d       = bus.PID_data;
            data_d      = bus.data;
            crc_d       = bus.CRC_data;
            send_data_d = bus.send_data;
            bit_cnt_d   = '0;
            busy_d      = 1'b1;
        end

        if (bit_tick && !stuff_now) begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    idx_d   = '0;
                end
                SYNC, PID, DATA, CRC: begin
                    if (idx_q == IDX_W'(field_bits(state_q) - 1)) begin
                        idx_d   = '0;
                        state_d = next_field(state_q, send_data_q);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                EOP_SE0_1: state_d = EOP_SE0_2;
                EOP_SE0_2: state_d = EOP_J;
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    eop_d   = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        raw_bit = 1'b1;
        case (state_d)
            SYNC:    raw_bit = SYNC_BYTE[idx_d[2:0]];
            PID:     raw_bit = pid_d[idx_d[2:0]];
            DATA:    raw_bit = data_d[idx_d[5:0]];
            CRC:     raw_bit = crc_d[idx_d[3:0]];
            default: raw_bit = 1'b1;
        endcase
    end

    assign se0_req = (state_d == EOP_SE0_1) || (state_d == EOP_SE0_2);

    usb_bit_encoder #(
        .STUFF_RUN (STUFF_RUN)
    ) u_enc (
        .clk        (clk),
        .rst        (rst),
        .raw_bit    (raw_bit),
        .bit_tick   (bit_tick),
        .se0_req    (se0_req),
        .pkt_start  (pkt_start),
        .line_state (line_state),
        .stuff_now  (stuff_now)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bit_cnt_q   <= '0;
            pid_q       <= '0;
            data_q      <= '0;
            crc_q       <= '0;
            send_data_q <= 1'b0;
            busy_q      <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bit_cnt_q   <= bit_cnt_d;
            pid_q       <= pid_d;
            data_q      <= data_d;
            crc_q       <= crc_d;
            send_data_q <= send_data_d;
            busy_q      <= busy_d;
            eop_q       <= eop_d;
        end
    end

    assign bus.USBdata  = line_state;
    assign bus.tx_en    = busy_q;
    assign bus.busy     = busy_q;
    assign bus.EOP_sent = eop_q;

endmodule
